tcc32_meas_ctrl: RTL and testbench
==================================

# tcc32_meas_ctrl

Measurement sequencer that sits in front of one EF_TCC32 timer/counter/capture core and drives its configuration and enable inputs. On a software start it programs the core for capture mode with a one-shot down-counting timeout, collects N capture samples, and reports their sum, minimum and maximum. It stops early on timeout or abort, so firmware issues one command instead of hand-sequencing the core's enables.

## Interface
Parameters:
- NW, 4, width of sample-count field; max samples = 2^NW-1
- AW, 36, accumulator width; must be ≥ 32+NW

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command pulse; accepted only in IDLE
- abort  in  1  level/pulse; terminates any busy operation
- cfg_event  in  2  capture edge select, passed to core cp_event
- cfg_clk_src  in  4  timer clock source, passed to core clk_src
- cfg_nsamp  in  NW  samples to collect; 0 treated as 1
- cfg_timeout  in  32  timeout period in timer ticks
- tcc_en  out  1  core enable (core en)
- tcc_tmr_en  out  1  core timer enable
- tcc_cp_en  out  1  core capture enable
- tcc_cp_event  out  2  latched cfg_event
- tcc_clk_src  out  4  latched cfg_clk_src
- tcc_period  out  32  latched cfg_timeout
- tcc_one_shot  out  1  constant 1 while busy, 0 in IDLE
- tcc_up  out  1  constant 0 (down count)
- cp_flag  in  1  core capture-done pulse; cp_count valid same cycle
- cp_count  in  32  core captured count
- to_flag  in  1  core timeout pulse
- busy  out  1  high in CFG, ARM, RUN, DONE
- done  out  1  one-cycle pulse at completion
- status  out  2  00 OK, 01 TIMEOUT, 10 ABORT
- n_got  out  NW  samples accumulated
- sum  out  AW  sum of captured counts
- min_cnt  out  32  smallest capture
- max_cnt  out  32  largest capture

## Operation
- FSM states: IDLE → CFG → ARM → RUN → DONE → IDLE.
- IDLE:
  - All tcc_* enables are 0.
  - On start, latch all cfg_* inputs (nsamp=0 becomes 1).
  - Clear sum, n_got and status to 0, min_cnt to 0xFFFF_FFFF, max_cnt to 0.
  - Go to CFG.
- CFG: tcc_en=1 and latched config is driven; tmr_en and cp_en stay 0. Go to ARM.
- ARM: tcc_tmr_en=1 and tcc_cp_en=1. Go to RUN.
- RUN, on cp_flag:
  - sum += zero-extended cp_count; n_got++.
  - min_cnt = min(min_cnt, cp_count); max_cnt = max(max_cnt, cp_count).
  - If the new n_got equals nsamp: status=OK, go to DONE.
- RUN, on to_flag:
  - status=TIMEOUT, go to DONE.
  - If cp_flag arrives in the same cycle, the sample is accumulated first. If that sample completes the count, OK wins over TIMEOUT.
- abort:
  - In CFG, ARM or RUN: status=ABORT, go to DONE next cycle.
  - Abort has highest priority; a same-cycle cp_flag is not accumulated.
  - Ignored in IDLE and DONE.
- DONE: tcc_en, tcc_tmr_en and tcc_cp_en = 0; done=1 for this single cycle. Go to IDLE.
- cp_flag and to_flag are ignored outside RUN.
- start is ignored while busy.
- Results (sum, min_cnt, max_cnt, n_got, status) hold from DONE until the next accepted start.
- Arithmetic: with AW ≥ 32+NW, sum cannot overflow; no saturation logic.

## Timing
- Reset values (asynchronous): state IDLE, all outputs 0 except min_cnt=0xFFFF_FFFF. tcc_up=0, tcc_one_shot=0.
- All outputs are registered; no combinational path from input to output.
- start sampled in IDLE at edge T:
  - busy=1 and CFG from T+1.
  - ARM at T+2; tcc_tmr_en and tcc_cp_en rise at T+2.
  - RUN from T+3.
- cp_flag sampled at edge E (last sample): results updated and DONE at E+1, done=1 during E+1, IDLE at E+2.
- Minimum start-to-done latency: 4 cycles (nsamp=1, cp_flag in first RUN cycle).
- A new start is accepted on the first IDLE cycle after DONE.
- rst_n asserted mid-operation: core enables drop immediately, results are cleared, no done pulse.

## Test plan
- Normal run: nsamp=3, cp_count 100, 50, 75 → done with status=00, n_got=3, sum=225, min=50, max=100; tmr_en/cp_en high exactly from ARM to RUN end.
- Timeout: nsamp=4, one cp_flag (count 40), then to_flag → status=01, n_got=1, sum=40, min=max=40, enables low in DONE.
- Simultaneous last sample and timeout: nsamp=2, second cp_flag (count 10) coincident with to_flag → status=00, n_got=2.
- Abort: abort in ARM, then abort in RUN coincident with cp_flag → status=10, that sample not counted, done pulse 1 cycle.
- Boundaries: cfg_nsamp=0 behaves as 1; cp_count=0xFFFF_FFFF ×15 → sum=0xE_FFFF_FFF1 with no wrap; start while busy is ignored.
- Reset mid-RUN: rst_n low → tcc_en/tmr_en/cp_en=0 asynchronously, min_cnt=0xFFFF_FFFF, busy=0, no done pulse.

Source files
------------

// File: rtl/tcc32_meas_ctrl_if.sv
// Signal bundle between the measurement sequencer and one EF_TCC32 core:
// enables/configuration toward the core, capture/timeout events back.
interface tcc32_meas_ctrl_if;
    logic        tcc_en;
    logic        tcc_tmr_en;
    logic        tcc_cp_en;
    logic [1:0]  tcc_cp_event;
    logic [3:0]  tcc_clk_src;
    logic [31:0] tcc_period;
    logic        tcc_one_shot;
    logic        tcc_up;
    logic        cp_flag;
    logic [31:0] cp_count;
    logic        to_flag;

    modport master (
        output tcc_en, tcc_tmr_en, tcc_cp_en, tcc_cp_event, tcc_clk_src,
               tcc_period, tcc_one_shot, tcc_up,
        input  cp_flag, cp_count, to_flag
    );

    modport slave (
        input  tcc_en, tcc_tmr_en, tcc_cp_en, tcc_cp_event, tcc_clk_src,
               tcc_period, tcc_one_shot, tcc_up,
        output cp_flag, cp_count, to_flag
    );
endinterface

// File: rtl/tcc32_meas_ctrl.sv
// Measurement sequencer for an EF_TCC32 core: arms capture with a one-shot
// timeout, collects N samples and reports sum/min/max with a completion status.
module tcc32_meas_ctrl #(
    parameter int unsigned NW = 4,
    parameter int unsigned AW = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           cfg_event,
    input  logic [3:0]           cfg_clk_src,
    input  logic [NW-1:0]        cfg_nsamp,
    input  logic [31:0]          cfg_timeout,
    tcc32_meas_ctrl_if.master    tcc,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [NW-1:0]        n_got,
    output logic [AW-1:0]        sum,
    output logic [31:0]          min_cnt,
    output logic [31:0]          max_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_ARM,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_ABORT   = 2'b10
    } status_e;

    state_e          state;
    state_e          state_nx;
    status_e         status_nx;
    logic            status_upd;
    logic            take;
    logic            last;
    logic [NW-1:0]   nsamp_q;
    logic [NW-1:0]   n_inc;

    always_comb begin
        state_nx   = state;
        status_nx  = ST_OK;
        status_upd = 1'b0;
        // abort outranks a same-cycle capture, so the sample is never taken
        take  = (state == S_RUN) && tcc.cp_flag && !abort;
        n_inc = n_got + NW'(1);
        last  = take && (n_inc == nsamp_q);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_CFG;
                end
            end
            S_CFG: begin
                if (abort) begin
                    state_nx   = S_DONE;
                    status_nx  = ST_ABORT;
                    status_upd = 1'b1;
                end else begin
                    state_nx = S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_nx   = S_DONE;
                    status_nx  = ST_ABORT;
                    status_upd = 1'b1;
                end else begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nx   = S_DONE;
                    status_nx  = ST_ABORT;
                    status_upd = 1'b1;
                end else if (last) begin
                    state_nx   = S_DONE;
                    status_nx  = ST_OK;
                    status_upd = 1'b1;
                end else if (tcc.to_flag) begin
                    state_nx   = S_DONE;
                    status_nx  = ST_TIMEOUT;
                    status_upd = 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            tcc.tcc_en       <= 1'b0;
            tcc.tcc_tmr_en   <= 1'b0;
            tcc.tcc_cp_en    <= 1'b0;
            tcc.tcc_one_shot <= 1'b0;
            tcc.tcc_cp_event <= '0;
            tcc.tcc_clk_src  <= '0;
            tcc.tcc_period   <= '0;
            nsamp_q          <= '0;
            status           <= '0;
            n_got            <= '0;
            sum              <= '0;
            min_cnt          <= '1;
            max_cnt          <= '0;
        end else begin
            busy             <= (state_nx != S_IDLE);
            done             <= (state_nx == S_DONE);
            tcc.tcc_en       <= (state_nx == S_CFG) || (state_nx == S_ARM) || (state_nx == S_RUN);
            tcc.tcc_tmr_en   <= (state_nx == S_ARM) || (state_nx == S_RUN);
            tcc.tcc_cp_en    <= (state_nx == S_ARM) || (state_nx == S_RUN);
            tcc.tcc_one_shot <= (state_nx != S_IDLE);

            if ((state == S_IDLE) && start) begin
                tcc.tcc_cp_event <= cfg_event;
                tcc.tcc_clk_src  <= cfg_clk_src;
                tcc.tcc_period   <= cfg_timeout;
                nsamp_q          <= (cfg_nsamp == '0) ? NW'(1) : cfg_nsamp;
                status           <= '0;
                n_got            <= '0;
                sum              <= '0;
                min_cnt          <= '1;
                max_cnt          <= '0;
            end

            if (take) begin
                sum   <= sum + AW'(tcc.cp_count);
                n_got <= n_inc;
                if (tcc.cp_count < min_cnt) begin
                    min_cnt <= tcc.cp_count;
                end
                if (tcc.cp_count > max_cnt) begin
                    max_cnt <= tcc.cp_count;
                end
            end

            if (status_upd) begin
                status <= status_nx;
            end
        end
    end

    assign tcc.tcc_up = 1'b0;

endmodule

// File: tb/tb_tcc32_meas_ctrl.sv
// Directed bench for tcc32_meas_ctrl: cycle-by-cycle vector table plus
// hand-written sequences for config latching, wide sums and async reset.
module tb_tcc32_meas_ctrl;
    localparam int NW = 4;
    localparam int AW = 36;
    localparam longint F = 64'h0000_0000_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start, abort;
    logic [1:0]      cfg_event;
    logic [3:0]      cfg_clk_src;
    logic [NW-1:0]   cfg_nsamp;
    logic [31:0]     cfg_timeout;
    logic            busy, done;
    logic [1:0]      status;
    logic [NW-1:0]   n_got;
    logic [AW-1:0]   sum;
    logic [31:0]     min_cnt, max_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tcc32_meas_ctrl_if tcc();

    tcc32_meas_ctrl #(.NW(NW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_event(cfg_event), .cfg_clk_src(cfg_clk_src),
        .cfg_nsamp(cfg_nsamp), .cfg_timeout(cfg_timeout),
        .tcc(tcc),
        .busy(busy), .done(done), .status(status), .n_got(n_got),
        .sum(sum), .min_cnt(min_cnt), .max_cnt(max_cnt)
    );

    typedef struct {
        logic        s, a, c, t;
        logic [31:0] cnt;
        logic [3:0]  ns;
        logic        b, d, e, tm, cp;
        logic [1:0]  st;
        logic [3:0]  ng;
        logic [35:0] sm;
        logic [31:0] mn, mx;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(input int s, input int a, input int c, input int t,
                                input longint cnt, input int ns,
                                input int b, input int d, input int e, input int tm,
                                input int cp, input int st, input int ng,
                                input longint sm, input longint mn, input longint mx);
        vec_t v;
        v.s = s[0]; v.a = a[0]; v.c = c[0]; v.t = t[0];
        v.cnt = cnt[31:0]; v.ns = ns[3:0];
        v.b = b[0]; v.d = d[0]; v.e = e[0]; v.tm = tm[0]; v.cp = cp[0];
        v.st = st[1:0]; v.ng = ng[3:0]; v.sm = sm[35:0];
        v.mn = mn[31:0]; v.mx = mx[31:0];
        return v;
    endfunction

    function automatic logic [111:0] outs();
        return {busy, done, tcc.tcc_en, tcc.tcc_tmr_en, tcc.tcc_cp_en,
                tcc.tcc_one_shot, status, n_got, sum, min_cnt, max_cnt};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             s a c t  cnt   ns | b d e tm cp st ng  sum  min  max
        // normal run, nsamp=3; start while busy / in DONE ignored
        vecs[0]  = mk(1,0,0,0,   0, 3,   1,0,1,0,0, 0,0,   0,  F,   0);
        vecs[1]  = mk(0,0,0,0,   0, 3,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[2]  = mk(0,0,0,0,   0, 3,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[3]  = mk(0,0,1,0, 100, 3,   1,0,1,1,1, 0,1, 100, 100, 100);
        vecs[4]  = mk(1,0,0,0,   0, 3,   1,0,1,1,1, 0,1, 100, 100, 100);
        vecs[5]  = mk(0,0,1,0,  50, 3,   1,0,1,1,1, 0,2, 150,  50, 100);
        vecs[6]  = mk(0,0,1,0,  75, 3,   1,1,0,0,0, 0,3, 225,  50, 100);
        vecs[7]  = mk(1,0,0,0,   0, 3,   0,0,0,0,0, 0,3, 225,  50, 100);
        // timeout, nsamp=4; events in DONE ignored
        vecs[8]  = mk(1,0,0,0,   0, 4,   1,0,1,0,0, 0,0,   0,  F,   0);
        vecs[9]  = mk(0,0,0,0,   0, 4,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[10] = mk(0,0,0,0,   0, 4,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[11] = mk(0,0,1,0,  40, 4,   1,0,1,1,1, 0,1,  40,  40,  40);
        vecs[12] = mk(0,0,0,1,   0, 4,   1,1,0,0,0, 1,1,  40,  40,  40);
        vecs[13] = mk(1,0,1,1,   7, 4,   0,0,0,0,0, 1,1,  40,  40,  40);
        // last sample coincident with timeout: OK wins; capture in CFG ignored
        vecs[14] = mk(1,0,0,0,   0, 2,   1,0,1,0,0, 0,0,   0,  F,   0);
        vecs[15] = mk(0,0,1,0, 999, 2,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[16] = mk(0,0,0,0,   0, 2,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[17] = mk(0,0,1,0,  20, 2,   1,0,1,1,1, 0,1,  20,  20,  20);
        vecs[18] = mk(0,0,1,1,  10, 2,   1,1,0,0,0, 0,2,  30,  10,  20);
        vecs[19] = mk(0,0,0,0,   0, 2,   0,0,0,0,0, 0,2,  30,  10,  20);
        // abort in ARM, abort ignored in DONE and IDLE
        vecs[20] = mk(1,0,0,0,   0, 3,   1,0,1,0,0, 0,0,   0,  F,   0);
        vecs[21] = mk(0,0,0,0,   0, 3,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[22] = mk(0,1,0,0,   0, 3,   1,1,0,0,0, 2,0,   0,  F,   0);
        vecs[23] = mk(0,1,0,0,   0, 3,   0,0,0,0,0, 2,0,   0,  F,   0);
        // start+abort in IDLE: start wins; abort with capture in RUN drops sample
        vecs[24] = mk(1,1,0,0,   0, 3,   1,0,1,0,0, 0,0,   0,  F,   0);
        vecs[25] = mk(0,0,0,0,   0, 3,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[26] = mk(0,0,0,0,   0, 3,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[27] = mk(0,0,1,0,   5, 3,   1,0,1,1,1, 0,1,   5,   5,   5);
        vecs[28] = mk(0,1,1,0,   9, 3,   1,1,0,0,0, 2,1,   5,   5,   5);
        vecs[29] = mk(0,0,0,0,   0, 3,   0,0,0,0,0, 2,1,   5,   5,   5);
        // nsamp=0 behaves as 1, minimum latency, zero-valued capture
        vecs[30] = mk(1,0,0,0,   0, 0,   1,0,1,0,0, 0,0,   0,  F,   0);
        vecs[31] = mk(0,0,0,0,   0, 0,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[32] = mk(0,0,0,0,   0, 0,   1,0,1,1,1, 0,0,   0,  F,   0);
        vecs[33] = mk(0,0,1,0,   0, 0,   1,1,0,0,0, 0,1,   0,   0,   0);
        vecs[34] = mk(0,0,0,0,   0, 0,   0,0,0,0,0, 0,1,   0,   0,   0);

        start = 1'b0; abort = 1'b0;
        cfg_event = 2'b10; cfg_clk_src = 4'h5; cfg_nsamp = '0; cfg_timeout = 32'd1000;
        tcc.cp_flag = 1'b0; tcc.cp_count = '0; tcc.to_flag = 1'b0;

        repeat (3) tick();
        check("reset_outs", 128'(outs()), 128'({6'b0, 2'b0, 4'b0, 36'b0, 32'hFFFF_FFFF, 32'b0}));
        check("reset_cfg", 128'({tcc.tcc_cp_event, tcc.tcc_clk_src, tcc.tcc_period, tcc.tcc_up}), 128'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 35; i++) begin
            start         = vecs[i].s;
            abort         = vecs[i].a;
            tcc.cp_flag   = vecs[i].c;
            tcc.to_flag   = vecs[i].t;
            tcc.cp_count  = vecs[i].cnt;
            cfg_nsamp     = vecs[i].ns;
            tick();
            check($sformatf("row%0d", i), 128'(outs()),
                  128'({vecs[i].b, vecs[i].d, vecs[i].e, vecs[i].tm, vecs[i].cp, vecs[i].b,
                        vecs[i].st, vecs[i].ng, vecs[i].sm, vecs[i].mn, vecs[i].mx}));
        end
        start = 1'b0; abort = 1'b0; tcc.cp_flag = 1'b0; tcc.to_flag = 1'b0;

        // configuration is latched at start and unaffected by later input changes
        cfg_event = 2'b01; cfg_clk_src = 4'hA; cfg_timeout = 32'd77; cfg_nsamp = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0; cfg_event = 2'b11; cfg_clk_src = 4'h3; cfg_timeout = 32'd5;
        check("cfg_latch", 128'({tcc.tcc_cp_event, tcc.tcc_clk_src, tcc.tcc_period, tcc.tcc_up, tcc.tcc_one_shot}),
              128'({2'b01, 4'hA, 32'd77, 1'b0, 1'b1}));
        tick();
        tick();
        check("cfg_hold_run", 128'({tcc.tcc_cp_event, tcc.tcc_clk_src, tcc.tcc_period}),
              128'({2'b01, 4'hA, 32'd77}));
        tcc.to_flag = 1'b1;
        tick();
        tcc.to_flag = 1'b0;
        check("to_only", 128'({done, status, n_got, tcc.tcc_en}), 128'({1'b1, 2'b01, 4'd0, 1'b0}));
        tick();
        check("to_idle", 128'({busy, done, tcc.tcc_one_shot}), 128'(0));

        // 15 full-scale captures: sum must not wrap
        cfg_nsamp = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 15; k++) begin
            tcc.cp_flag = 1'b1; tcc.cp_count = 32'hFFFF_FFFF;
            tick();
        end
        tcc.cp_flag = 1'b0; tcc.cp_count = '0;
        check("big_done", 128'({done, status, n_got}), 128'({1'b1, 2'b00, 4'd15}));
        check("big_sum", 128'(sum), 128'(36'hE_FFFF_FFF1));
        check("big_minmax", 128'({min_cnt, max_cnt}), 128'({32'hFFFF_FFFF, 32'hFFFF_FFFF}));
        tick();
        check("big_done_pulse", 128'({busy, done}), 128'(0));

        // asynchronous reset in RUN after one sample
        cfg_nsamp = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tcc.cp_flag = 1'b1; tcc.cp_count = 32'd12;
        tick();
        tcc.cp_flag = 1'b0;
        check("pre_rst_run", 128'({tcc.tcc_en, tcc.tcc_tmr_en, n_got, sum[31:0]}),
              128'({1'b1, 1'b1, 4'd1, 32'd12}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 128'(outs()), 128'({6'b0, 2'b0, 4'b0, 36'b0, 32'hFFFF_FFFF, 32'b0}));
        tick();
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (done || busy) seen++;
            end
            check("post_rst_quiet", 128'(seen), 128'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
